// File: rtl/sa_pkg.sv
// Shared encodings and defaults for the systolic-array processing elements.
package sa_pkg;

    localparam logic MODE_OS = 1'b0;
    localparam logic MODE_WS = 1'b1;

    localparam int SA_DATA_W = 8;
    localparam int SA_ACC_W  = 32;

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/sa_pe_mm_if.sv
// Operand, psum and control bundle of one PE; master drives the PE, slave is the PE.
interface sa_pe_mm_if
    import sa_pkg::*;
#(
    parameter int DATA_W = SA_DATA_W,
    parameter int ACC_W  = SA_ACC_W
);
    logic                     flush;
    logic                     mode;
    logic                     load_w;
    logic                     drain;
    logic signed [DATA_W-1:0] in_north;
    logic                     in_north_valid;
    logic signed [DATA_W-1:0] in_west;
    logic                     in_west_valid;
    logic signed [ACC_W-1:0]  in_psum;
    logic                     in_psum_valid;
    logic signed [DATA_W-1:0] out_south;
    logic                     out_south_valid;
    logic signed [DATA_W-1:0] out_east;
    logic                     out_east_valid;
    logic signed [ACC_W-1:0]  out_psum;
    logic                     out_psum_valid;
    logic signed [ACC_W-1:0]  result;
    logic                     sat_flag;

    modport master (
        output flush, mode, load_w, drain,
        output in_north, in_north_valid, in_west, in_west_valid, in_psum, in_psum_valid,
        input  out_south, out_south_valid, out_east, out_east_valid,
        input  out_psum, out_psum_valid, result, sat_flag
    );

    modport slave (
        input  flush, mode, load_w, drain,
        input  in_north, in_north_valid, in_west, in_west_valid, in_psum, in_psum_valid,
        output out_south, out_south_valid, out_east, out_east_valid,
        output out_psum, out_psum_valid, result, sat_flag
    );

endinterface

// File: rtl/sa_sat_add.sv
// ACC_W-bit signed accumulate of a sign-extended product, clamped or wrapped.
module sa_sat_add #(
    parameter int ACC_W = 32,
    parameter bit SAT   = 1'b1
) (
    input  logic signed [ACC_W-1:0] a_i,
    input  logic signed [ACC_W:0]   b_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic                    sat_o
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    logic signed [ACC_W:0] full_d;
    logic                  ovf_d;

    assign full_d = (ACC_W+1)'(a_i) + b_i;
    // Top two bits disagree exactly when the true sum left the ACC_W range.
    assign ovf_d  = full_d[ACC_W] ^ full_d[ACC_W-1];

    always_comb begin
        sum_o = full_d[ACC_W-1:0];
        sat_o = 1'b0;
        if (SAT) begin
            sum_o = sat_clip(full_d);
            sat_o = ovf_d;
        end
    end

endmodule

// File: rtl/sa_pe_mm.sv
// Systolic PE with output-stationary (local accumulate + drain chain) and weight-stationary dataflows.
module sa_pe_mm
    import sa_pkg::*;
#(
    parameter int DATA_W  = SA_DATA_W,
    parameter int ACC_W   = SA_ACC_W,
    parameter bit SAT     = 1'b1,
    parameter int ROW_IDX = 0
) (
    input logic         clk,
    input logic         rst_n,
    sa_pe_mm_if.slave   pe
);

    localparam int CNT_W = $clog2(ROW_IDX + 2);

    state_t                   state_q;
    logic                     mode_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [DATA_W-1:0] w_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  psum_q;
    logic                     psum_vld_q;
    logic signed [DATA_W-1:0] south_q, east_q;
    logic                     south_vld_q, east_vld_q;
    logic                     sat_q;

    logic                       is_ws, mac_en;
    logic signed [DATA_W-1:0]   mul_a;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W:0]      prod_ext;
    logic signed [ACC_W-1:0]    add_a;
    logic signed [ACC_W-1:0]    sum_d;
    logic                       sat_d;

    // One adder serves both dataflows: OS adds into acc, WS adds onto the incoming psum.
    assign is_ws    = (mode_q == MODE_WS);
    assign mac_en   = is_ws ? pe.in_west_valid : (pe.in_north_valid & pe.in_west_valid);
    assign mul_a    = is_ws ? w_q : pe.in_north;
    assign prod     = (2*DATA_W)'(mul_a) * (2*DATA_W)'(pe.in_west);
    assign prod_ext = mac_en ? (ACC_W+1)'(prod) : '0;
    assign add_a    = is_ws ? pe.in_psum : acc_q;

    sa_sat_add #(.ACC_W(ACC_W), .SAT(SAT)) u_add (
        .a_i   (add_a),
        .b_i   (prod_ext),
        .sum_o (sum_d),
        .sat_o (sat_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            mode_q      <= MODE_OS;
            cnt_q       <= '0;
            w_q         <= '0;
            acc_q       <= '0;
            psum_q      <= '0;
            psum_vld_q  <= 1'b0;
            south_q     <= '0;
            south_vld_q <= 1'b0;
            east_q      <= '0;
            east_vld_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else if (pe.flush) begin
            state_q     <= ST_ACC;
            mode_q      <= pe.mode;
            cnt_q       <= '0;
            w_q         <= '0;
            acc_q       <= '0;
            psum_q      <= '0;
            psum_vld_q  <= 1'b0;
            south_q     <= '0;
            south_vld_q <= 1'b0;
            east_q      <= '0;
            east_vld_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            south_q     <= pe.in_north;
            south_vld_q <= pe.in_north_valid;
            east_q      <= pe.in_west;
            east_vld_q  <= pe.in_west_valid;
            sat_q       <= sat_q | sat_d;
            if (is_ws) begin
                // The MAC this cycle still sees the old weight.
                if (pe.load_w && pe.in_north_valid) w_q <= pe.in_north;
                psum_vld_q <= pe.in_west_valid;
                if (pe.in_west_valid) psum_q <= sum_d;
            end else begin
                case (state_q)
                    ST_ACC: begin
                        if (pe.drain) begin
                            psum_q     <= sum_d;
                            psum_vld_q <= 1'b1;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            if (ROW_IDX > 0) state_q <= ST_DRAIN;
                        end else begin
                            psum_vld_q <= 1'b0;
                            if (mac_en) acc_q <= sum_d;
                        end
                    end
                    ST_DRAIN: begin
                        // Forward the results of the PEs above; new MACs start the next tile.
                        psum_q     <= pe.in_psum;
                        psum_vld_q <= pe.in_psum_valid;
                        if (mac_en) acc_q <= sum_d;
                        if (pe.in_psum_valid) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q + CNT_W'(1) == CNT_W'(ROW_IDX)) state_q <= ST_ACC;
                        end
                    end
                    default: state_q <= ST_ACC;
                endcase
            end
        end
    end

    assign pe.out_south       = south_q;
    assign pe.out_south_valid = south_vld_q;
    assign pe.out_east        = east_q;
    assign pe.out_east_valid  = east_vld_q;
    assign pe.out_psum        = psum_q;
    assign pe.out_psum_valid  = psum_vld_q;
    assign pe.result          = acc_q;
    assign pe.sat_flag        = sat_q;

endmodule

// File: tb/tb_sa_pe_mm.sv
// Scoreboard bench for sa_pe_mm: a drain-chain PE (ROW_IDX=2) plus 16-bit clamping and wrapping PEs.
module tb_sa_pe_mm;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sa_pe_mm_if #(.DATA_W(8), .ACC_W(32)) mi ();
    sa_pe_mm_if #(.DATA_W(8), .ACC_W(16)) si ();
    sa_pe_mm_if #(.DATA_W(8), .ACC_W(16)) wi ();

    sa_pe_mm #(.DATA_W(8), .ACC_W(32), .SAT(1'b1), .ROW_IDX(2)) u_m (.clk(clk), .rst_n(rst_n), .pe(mi));
    sa_pe_mm #(.DATA_W(8), .ACC_W(16), .SAT(1'b1), .ROW_IDX(0)) u_s (.clk(clk), .rst_n(rst_n), .pe(si));
    sa_pe_mm #(.DATA_W(8), .ACC_W(16), .SAT(1'b0), .ROW_IDX(0)) u_w (.clk(clk), .rst_n(rst_n), .pe(wi));

    int n_chk  = 0;
    int n_fail = 0;

    logic signed [31:0] exp_psum[$];
    logic signed [7:0]  exp_east[$];
    logic signed [7:0]  exp_south[$];

    task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic signed [63:0] got);
        n_chk++;
        n_fail++;
        $display("FAIL %s got=%0d expected=no valid output", nm, got);
    endtask

    // Monitor: every valid output word of the main PE must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mi.out_psum_valid === 1'b1) begin
                if (exp_psum.size() == 0) unexpected("out_psum_unexpected", mi.out_psum);
                else check("out_psum", mi.out_psum, exp_psum.pop_front());
            end
            if (mi.out_east_valid === 1'b1) begin
                if (exp_east.size() == 0) unexpected("out_east_unexpected", mi.out_east);
                else check("out_east", mi.out_east, exp_east.pop_front());
            end
            if (mi.out_south_valid === 1'b1) begin
                if (exp_south.size() == 0) unexpected("out_south_unexpected", mi.out_south);
                else check("out_south", mi.out_south, exp_south.pop_front());
            end
        end
    end

    task automatic tick();
        if (!mi.flush) begin
            if (mi.in_west_valid)  exp_east.push_back(mi.in_west);
            if (mi.in_north_valid) exp_south.push_back(mi.in_north);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mset(input logic nv, input logic signed [7:0] n, input logic wv, input logic signed [7:0] w);
        mi.in_north_valid = nv;
        mi.in_north       = n;
        mi.in_west_valid  = wv;
        mi.in_west        = w;
    endtask

    task automatic sw_set(input logic v, input logic signed [7:0] n, input logic signed [7:0] w, input logic fl);
        si.in_north_valid = v; si.in_west_valid = v; si.in_north = n; si.in_west = w; si.flush = fl;
        wi.in_north_valid = v; wi.in_west_valid = v; wi.in_north = n; wi.in_west = w; wi.flush = fl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mi.flush = 0; mi.mode = 0; mi.load_w = 0; mi.drain = 0;
        mi.in_psum = '0; mi.in_psum_valid = 0;
        mset(0, 0, 0, 0);
        si.mode = 0; si.load_w = 0; si.drain = 0; si.in_psum = '0; si.in_psum_valid = 0;
        wi.mode = 0; wi.load_w = 0; wi.drain = 0; wi.in_psum = '0; wi.in_psum_valid = 0;
        sw_set(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", mi.result, 0);
        check("reset_out_psum_valid", mi.out_psum_valid, 0);
        check("reset_sat_flag", mi.sat_flag, 0);
        check("reset_out_south", mi.out_south, 0);
        rst_n = 1'b1;

        // OS accumulate
        mi.flush = 1; mi.mode = 0; tick(); mi.flush = 0;
        mset(1, 3, 1, 4);   tick(); check("os_acc1", mi.result, 12);
        mset(1, -2, 1, 5);  tick(); check("os_acc2", mi.result, 2);
        mset(1, 7, 1, -1);  tick(); check("os_acc3", mi.result, -5);

        // west operand invalid: no MAC, no east valid
        for (int i = 0; i < 3; i++) begin
            mset(1, 9, 0, 9); tick();
            check("gate_result", mi.result, -5);
            check("gate_east_valid", mi.out_east_valid, 0);
        end

        // drain with a same-cycle MAC, then forward two words from above
        mset(1, 2, 1, 3); mi.drain = 1; exp_psum.push_back(1); tick();
        check("drain_acc_clear", mi.result, 0);
        mset(1, 1, 1, 1); mi.drain = 1;
        mi.in_psum = 100; mi.in_psum_valid = 1; exp_psum.push_back(100); tick();
        mset(0, 0, 0, 0); mi.drain = 0;
        mi.in_psum = 200; mi.in_psum_valid = 1; exp_psum.push_back(200); tick();
        check("drain_mac_into_fresh_acc", mi.result, 1);
        mi.in_psum = 77; mi.in_psum_valid = 1; tick();
        check("after_drain_no_valid", mi.out_psum_valid, 0);
        mi.in_psum_valid = 0; mi.drain = 1; exp_psum.push_back(1); tick();
        mi.drain = 0;
        mi.in_psum = 5; mi.in_psum_valid = 1; exp_psum.push_back(5); tick();
        mi.in_psum = 6; mi.in_psum_valid = 1; exp_psum.push_back(6); tick();
        mi.in_psum_valid = 0; tick();
        check("drain2_done", mi.out_psum_valid, 0);

        // 16-bit saturation vs wrap
        sw_set(0, 0, 0, 1); tick();
        sw_set(1, -128, -128, 0); tick();
        check("sat_r1", si.result, 16384);  check("wrap_r1", wi.result, 16384);
        tick();
        check("sat_r2", si.result, 32767);  check("wrap_r2", wi.result, -32768);
        check("sat_flag_set", si.sat_flag, 1); check("wrap_flag_clear", wi.sat_flag, 0);
        tick();
        check("sat_r3", si.result, 32767);  check("wrap_r3", wi.result, -16384);
        sw_set(0, 0, 0, 0); tick();
        check("sat_flag_sticky", si.sat_flag, 1);
        sw_set(0, 0, 0, 1); tick(); sw_set(0, 0, 0, 0);
        check("sat_flag_flushed", si.sat_flag, 0);
        check("sat_result_flushed", si.result, 0);

        // weight-stationary
        mi.flush = 1; mi.mode = 1; tick(); mi.flush = 0;
        mi.load_w = 1; mset(1, -3, 0, 0); tick();
        mi.load_w = 0; mset(0, 0, 1, 4); mi.in_psum = 10; exp_psum.push_back(-2); tick();
        mi.load_w = 1; mset(1, 5, 1, 2); mi.in_psum = 0; exp_psum.push_back(-6); tick();
        mi.load_w = 0; mi.mode = 0; mset(0, 0, 1, 2); exp_psum.push_back(10); tick();
        check("ws_result_zero", mi.result, 0);
        mset(0, 0, 0, 0); tick();
        check("ws_idle_no_valid", mi.out_psum_valid, 0);
        check("ws_psum_hold", mi.out_psum, 10);

        // reset mid-drain
        mi.flush = 1; mi.mode = 0; tick(); mi.flush = 0;
        mset(1, 2, 1, 2); tick();
        mset(0, 0, 0, 0); mi.drain = 1; exp_psum.push_back(4); tick();
        mi.drain = 0; mset(1, 3, 1, 3); tick();
        check("drain_state_mac", mi.result, 9);
        mset(0, 0, 0, 0);
        @(negedge clk); #1;
        rst_n = 1'b0; #1;
        check("rst_result", mi.result, 0);
        check("rst_out_psum", mi.out_psum, 0);
        check("rst_out_south", mi.out_south, 0);
        check("rst_out_south_valid", mi.out_south_valid, 0);
        check("rst_out_psum_valid", mi.out_psum_valid, 0);
        rst_n = 1'b1;
        mset(1, 1, 1, 1); mi.drain = 1; exp_psum.push_back(1); tick();

        // flush beats a concurrent drain and MAC
        mi.drain = 0; mset(1, 2, 1, 5); tick();
        check("pre_flush_acc", mi.result, 10);
        mi.flush = 1; mi.drain = 1; mset(1, 1, 1, 1); mi.in_psum = 33; mi.in_psum_valid = 1; tick();
        mi.flush = 0; mi.drain = 0; mset(0, 0, 0, 0); mi.in_psum_valid = 0;
        check("flush_result", mi.result, 0);
        check("flush_psum_valid", mi.out_psum_valid, 0);
        check("flush_east_valid", mi.out_east_valid, 0);
        check("flush_out_psum", mi.out_psum, 0);
        tick();
        mi.drain = 1; exp_psum.push_back(0); tick(); mi.drain = 0;
        tick(); tick();

        check("psum_queue_drained", exp_psum.size(), 0);
        check("east_queue_drained", exp_east.size(), 0);
        check("south_queue_drained", exp_south.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_pe_mm.md
Name: sa_pe_mm

Overview:
- Parametrised systolic-array processing element; successor to the 8-bit output-stationary PE.
- Supports two dataflows, selected at flush time:
  - Output-stationary (OS): local accumulate, then a drain shift-out.
  - Weight-stationary (WS): stationary weight, partial sums flow north to south.
- Adds valid qualification, optional saturation with sticky flag, and a per-column result drain chain.
- Tiles into an R x C grid; column PE k has ROW_IDX=k.

Parameters:
- DATA_W, 8, signed operand width.
- ACC_W, 32, signed accumulator / psum width (must be >= 2*DATA_W).
- SAT, 1, 1 = clamp accumulations to ACC_W signed range; 0 = wrap.
- ROW_IDX, 0, number of PEs above this one in the column (words to forward during drain).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear; also latches mode
- mode  in  1  0=OS, 1=WS; sampled only on flush
- load_w  in  1  WS: with in_north_valid, capture in_north as weight
- drain  in  1  OS: one-cycle pulse starting result shift-out
- in_north  in  DATA_W  operand from north (OS) / weight chain (WS)
- in_north_valid  in  1
- in_west  in  DATA_W  operand from west
- in_west_valid  in  1
- in_psum  in  ACC_W  psum (WS) / drain data (OS) from north
- in_psum_valid  in  1
- out_south, out_south_valid  out  DATA_W, 1  registered in_north / valid
- out_east, out_east_valid  out  DATA_W, 1  registered in_west / valid
- out_psum, out_psum_valid  out  ACC_W, 1  psum / drain output to south
- result  out  ACC_W  OS accumulator value (WS: 0)
- sat_flag  out  1  sticky: a saturation occurred since last flush

Behaviour:

Reset:
- Asynchronous, active-low.
- All outputs, the accumulator, the weight register and mode_q are 0.
- State is ACC.
- Reset mid-drain aborts the drain with no partial output.

Flush:
- Highest priority.
- Clears the accumulator, weight, all out_* registers and valids, and sat_flag.
- Sets mode_q <= mode and state <= ACC.

Forwarding (both modes):
- out_south/out_east register in_north/in_west every cycle.
- Their valids register the input valids.
- Latency 1.

Product and arithmetic:
- prod = signed in_north * signed in_west, 2*DATA_W bits, sign-extended to ACC_W+1.
- sum = operand + prod at ACC_W+1 bits.
- If SAT: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set sat_flag when clamped.
- Else: truncate.

OS mode FSM, states ACC and DRAIN:
- ACC:
  - If in_north_valid & in_west_valid: acc <= f(acc + prod); otherwise hold.
  - result = acc.
- ACC with drain=1:
  - out_psum <= f(acc + prod_if_valid); the drain-cycle MAC is included.
  - out_psum_valid <= 1; acc <= 0; cnt <= 0.
  - Next state is DRAIN if ROW_IDX > 0, else stay in ACC.
- DRAIN:
  - out_psum <= in_psum; out_psum_valid <= in_psum_valid.
  - cnt increments on each in_psum_valid.
  - When cnt reaches ROW_IDX, go to ACC.
  - MACs during DRAIN accumulate into the fresh acc.
- drain asserted in DRAIN is ignored.
- drain in WS mode is ignored.
- Outside a drain, out_psum_valid is 0.

WS mode:
- load_w & in_north_valid: w <= in_north. The value still forwards south (weights shift down the column).
- Compute:
  - out_psum <= f(in_psum + w*in_west); out_psum_valid <= in_west_valid.
  - If in_west_valid=0, out_psum holds and out_psum_valid=0.
  - in_psum_valid is not checked; a north-edge PE is tied to in_psum=0.
- load_w together with in_west_valid: the MAC uses the old w; the new w applies next cycle.
- result stays 0.

Mode changes without flush have no effect.

Decomposition:
- Package sa_pkg: mode encodings (MODE_OS=0, MODE_WS=1), state enum (ST_ACC, ST_DRAIN), default DATA_W/ACC_W.
- One sub-module, sa_sat_add: combinational ACC_W+1 add with optional clamp and overflow flag. It is used for both the OS accumulate and the WS psum.
- The FSM, drain counter and registers stay in sa_pe_mm.

Test Plan:
1. OS accumulate: flush with mode=0; feed (3,4), (-2,5), (7,-1), all valid -> result 12, 2, -5; out_south/out_east echo inputs 1 cycle later with valids.
2. Valid gating: in_north=9, in_west=9 with in_west_valid=0 for 3 cycles -> result unchanged; out_east_valid=0.
3. Drain, ROW_IDX=2: acc=-5; pulse drain with a valid (2,3) in the same cycle -> out_psum=1 with valid next cycle, acc=0. Feed in_psum 100, 200 valid -> forwarded at 1 cycle each. State returns to ACC after the second word; a drain pulse during DRAIN is ignored.
4. Saturation, DATA_W=8, ACC_W=16, SAT=1: repeat (-128,-128) x3 -> result 16384, 32767 (clamped), 32767; sat_flag=1 until flush. With SAT=0, wraps to -16384 (16384 then -32768 then -16384) and sat_flag stays 0.
5. WS: flush with mode=1; load_w with in_north=-3; then in_west=4, in_psum=10, valid -> out_psum=-2. load_w=5 concurrently with in_west=2, in_psum=0 -> out_psum=-6; next in_west=2 -> 10.
6. Reset/flush priority: assert rst_n=0 mid-DRAIN -> all outputs 0 immediately, state ACC. Flush concurrent with drain and valid MAC -> everything 0 next cycle, no out_psum_valid.
